// File: rtl/ex_mem.sv
// EX/MEM pipeline stage: latches EX results, runs the data-memory handshake,
// and produces forwarding, load-use stall and register-file writeback.
module ex_mem #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [XLEN-1:0]       ex_result,
    input  logic [XLEN-1:0]       ex_mem_addr,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_mem_width,
    input  logic [REG_ADDR_W-1:0] id_r1_addr,
    input  logic [REG_ADDR_W-1:0] id_r2_addr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    output logic [2:0]            mem_width,
    input  logic                  mem_done,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  forward_ex_enable,
    output logic [REG_ADDR_W-1:0] forward_ex_addr,
    output logic [XLEN-1:0]       forward_ex_data,
    output logic                  forward_mem_enable,
    output logic [REG_ADDR_W-1:0] forward_mem_addr,
    output logic [XLEN-1:0]       forward_mem_data,
    output logic                  stall_out,
    output logic                  wb_enable,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]       wb_data
);

    typedef enum logic {IDLE, MEM_WAIT} state_e;

    state_e                state_q;
    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       result_q;
    logic [XLEN-1:0]       addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic [2:0]            width_q;
    logic                  is_load_q;
    logic                  is_store_q;
    logic                  ld_done_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic                  wb_en_q;

    logic ex_rd_nz;
    logic load_use;
    logic take;

    assign ex_rd_nz = (ex_rd_addr != '0);
    assign take     = ex_valid & ~clear;

    assign forward_ex_enable = ex_valid & ~ex_is_load & ex_rd_nz;
    assign forward_ex_addr   = ex_rd_addr;
    assign forward_ex_data   = ex_result;

    // The stall holds the consumer in ID; the load itself still advances.
    assign load_use = ex_valid & ex_is_load & ex_rd_nz &
                      ((ex_rd_addr == id_r1_addr) |
                       (ex_rd_addr == id_r2_addr));
    assign stall_out = load_use | ((state_q == MEM_WAIT) & ~mem_done);

    assign forward_mem_enable = valid_q & (rd_q != '0) & ~is_store_q &
                                (~is_load_q | ld_done_q);
    assign forward_mem_addr   = rd_q;
    assign forward_mem_data   = result_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_width = width_q;

    assign wb_enable = wb_en_q;
    assign wb_addr   = rd_q;
    assign wb_data   = result_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            width_q    <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            ld_done_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_en_q    <= 1'b0;
        end else if (rdy_in) begin
            unique case (state_q)
                IDLE: begin
                    wb_en_q   <= 1'b0;
                    ld_done_q <= 1'b0;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (take) begin
                        valid_q    <= 1'b1;
                        rd_q       <= ex_rd_addr;
                        result_q   <= ex_result;
                        addr_q     <= ex_mem_addr;
                        wdata_q    <= ex_store_data;
                        width_q    <= ex_mem_width;
                        is_load_q  <= ex_is_load;
                        is_store_q <= ex_is_store;
                        if (ex_is_load | ex_is_store) begin
                            state_q   <= MEM_WAIT;
                            mem_req_q <= 1'b1;
                            mem_we_q  <= ex_is_store;
                        end else begin
                            wb_en_q <= ex_rd_nz;
                        end
                    end else begin
                        valid_q    <= 1'b0;
                        rd_q       <= '0;
                        is_load_q  <= 1'b0;
                        is_store_q <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_done) begin
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (is_load_q) begin
                            result_q  <= mem_rdata;
                            ld_done_q <= 1'b1;
                            wb_en_q   <= (rd_q != '0);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: writebacks are checked by a scoreboard monitor,
// handshake/forwarding/stall outputs by inline checks.
module tb_ex_mem;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        ex_valid;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_result;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_store_data;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_mem_width;
    logic [4:0]  id_r1_addr;
    logic [4:0]  id_r2_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_width;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        forward_ex_enable;
    logic [4:0]  forward_ex_addr;
    logic [31:0] forward_ex_data;
    logic        forward_mem_enable;
    logic [4:0]  forward_mem_addr;
    logic [31:0] forward_mem_data;
    logic        stall_out;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];

    ex_mem #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .clear             (clear),
        .ex_valid          (ex_valid),
        .ex_rd_addr        (ex_rd_addr),
        .ex_result         (ex_result),
        .ex_mem_addr       (ex_mem_addr),
        .ex_store_data     (ex_store_data),
        .ex_is_load        (ex_is_load),
        .ex_is_store       (ex_is_store),
        .ex_mem_width      (ex_mem_width),
        .id_r1_addr        (id_r1_addr),
        .id_r2_addr        (id_r2_addr),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_width         (mem_width),
        .mem_done          (mem_done),
        .mem_rdata         (mem_rdata),
        .forward_ex_enable (forward_ex_enable),
        .forward_ex_addr   (forward_ex_addr),
        .forward_ex_data   (forward_ex_data),
        .forward_mem_enable(forward_mem_enable),
        .forward_mem_addr  (forward_mem_addr),
        .forward_mem_data  (forward_mem_data),
        .stall_out         (stall_out),
        .wb_enable         (wb_enable),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data)
    );

    always #5 clk_in = ~clk_in;

    // Scoreboard monitor: every writeback must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_in && wb_enable) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, expected none",
                         wb_addr, wb_data);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                if (wb_addr !== e.addr || wb_data !== e.data) begin
                    failures++;
                    $display("FAIL wb_match: got %0d/%h, expected %0d/%h",
                             wb_addr, wb_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [31:0] d);
        wb_t e;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ex_none();
        ex_valid      = 1'b0;
        ex_rd_addr    = '0;
        ex_result     = '0;
        ex_mem_addr   = '0;
        ex_store_data = '0;
        ex_is_load    = 1'b0;
        ex_is_store   = 1'b0;
        ex_mem_width  = 3'b010;
    endtask

    task automatic ex_alu(input logic [4:0] rd, input logic [31:0] res);
        ex_none();
        ex_valid   = 1'b1;
        ex_rd_addr = rd;
        ex_result  = res;
    endtask

    task automatic ex_load(input logic [4:0] rd, input logic [31:0] a);
        ex_none();
        ex_valid    = 1'b1;
        ex_rd_addr  = rd;
        ex_mem_addr = a;
        ex_is_load  = 1'b1;
    endtask

    task automatic ex_store(input logic [31:0] a, input logic [31:0] d);
        ex_none();
        ex_valid      = 1'b1;
        ex_mem_addr   = a;
        ex_store_data = d;
        ex_is_store   = 1'b1;
    endtask

    task automatic alu_5_1234();
        ex_alu(5'd5, 32'h1234);
        #1;
        chk("fex_en", {31'd0, forward_ex_enable}, 32'd1);
        chk("fex_addr", {27'd0, forward_ex_addr}, 32'd5);
        chk("fex_data", forward_ex_data, 32'h1234);
        expect_wb(5'd5, 32'h1234);
        tick();
        ex_none();
        #1;
        chk("fmem_en", {31'd0, forward_mem_enable}, 32'd1);
        chk("fmem_addr", {27'd0, forward_mem_addr}, 32'd5);
        chk("fmem_data", forward_mem_data, 32'h1234);
        chk("alu_wb_en", {31'd0, wb_enable}, 32'd1);
        tick();
        chk("alu_wb_drop", {31'd0, wb_enable}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in     = 1'b0;
        rdy_in     = 1'b1;
        clear      = 1'b0;
        id_r1_addr = '0;
        id_r2_addr = '0;
        mem_done   = 1'b0;
        mem_rdata  = '0;
        ex_none();
        #2;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_enable}, 32'd0);
        chk("rst_fmem_en", {31'd0, forward_mem_enable}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        #20;
        rst_in = 1'b1;
        tick();

        // ALU op: forward same cycle, writeback next cycle
        alu_5_1234();

        // both forward paths live on the same register
        ex_alu(5'd5, 32'h1);
        expect_wb(5'd5, 32'h1);
        tick();
        ex_alu(5'd5, 32'h99);
        expect_wb(5'd5, 32'h99);
        #1;
        chk("both_fex", {31'd0, forward_ex_enable}, 32'd1);
        chk("both_fmem", {31'd0, forward_mem_enable}, 32'd1);
        chk("both_fmem_data", forward_mem_data, 32'h1);
        tick();
        ex_none();
        tick();

        // load-use on r2, 3-cycle memory
        ex_load(5'd7, 32'h40);
        id_r2_addr = 5'd7;
        #1;
        chk("lu_stall", {31'd0, stall_out}, 32'd1);
        chk("ld_no_fex", {31'd0, forward_ex_enable}, 32'd0);
        expect_wb(5'd7, 32'hDEAD);
        tick();
        ex_none();
        id_r2_addr = '0;
        #1;
        chk("ld_req", {31'd0, mem_req}, 32'd1);
        chk("ld_we", {31'd0, mem_we}, 32'd0);
        chk("ld_addr", mem_addr, 32'h40);
        chk("ld_wait_stall", {31'd0, stall_out}, 32'd1);
        chk("ld_no_fmem", {31'd0, forward_mem_enable}, 32'd0);
        tick();
        chk("ld_req_hold", {31'd0, mem_req}, 32'd1);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'hDEAD;
        #1;
        chk("ld_done_unstall", {31'd0, stall_out}, 32'd0);
        tick();
        mem_done  = 1'b0;
        mem_rdata = '0;
        #1;
        chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
        chk("ld_wb_en", {31'd0, wb_enable}, 32'd1);
        chk("ld_fmem_en", {31'd0, forward_mem_enable}, 32'd1);
        chk("ld_fmem_addr", {27'd0, forward_mem_addr}, 32'd7);
        chk("ld_fmem_data", forward_mem_data, 32'hDEAD);
        tick();

        // store: request held until done, no writeback
        ex_store(32'h100, 32'hAB);
        tick();
        ex_none();
        for (int i = 0; i < 3; i++) begin
            chk("st_req", {31'd0, mem_req}, 32'd1);
            chk("st_we", {31'd0, mem_we}, 32'd1);
            chk("st_addr", mem_addr, 32'h100);
            chk("st_wdata", mem_wdata, 32'hAB);
            if (i == 2) mem_done = 1'b1;
            tick();
        end
        mem_done = 1'b0;
        chk("st_req_drop", {31'd0, mem_req}, 32'd0);
        chk("st_we_drop", {31'd0, mem_we}, 32'd0);
        chk("st_no_wb", {31'd0, wb_enable}, 32'd0);
        tick();

        // clear during MEM_WAIT does not abort the load
        ex_load(5'd9, 32'h80);
        expect_wb(5'd9, 32'h55);
        tick();
        ex_alu(5'd10, 32'h77);
        clear = 1'b1;
        tick();
        chk("clr_req_hold", {31'd0, mem_req}, 32'd1);
        tick();
        clear = 1'b0;
        ex_none();
        mem_done  = 1'b1;
        mem_rdata = 32'h55;
        tick();
        mem_done = 1'b0;
        chk("clr_ld_wb", {31'd0, wb_enable}, 32'd1);
        tick();

        // clear while idle squashes the accepted op
        ex_alu(5'd11, 32'h66);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ex_none();
        chk("clr_no_wb", {31'd0, wb_enable}, 32'd0);
        chk("clr_no_fmem", {31'd0, forward_mem_enable}, 32'd0);

        // x0 destination: no forward, no stall, no writeback
        ex_alu(5'd0, 32'h5A);
        #1;
        chk("x0_no_fex", {31'd0, forward_ex_enable}, 32'd0);
        tick();
        chk("x0_alu_no_wb", {31'd0, wb_enable}, 32'd0);
        ex_load(5'd0, 32'hC0);
        id_r1_addr = 5'd0;
        #1;
        chk("x0_no_stall", {31'd0, stall_out}, 32'd0);
        tick();
        ex_none();
        mem_done  = 1'b1;
        mem_rdata = 32'h1;
        tick();
        mem_done = 1'b0;
        chk("x0_ld_no_wb", {31'd0, wb_enable}, 32'd0);
        chk("x0_ld_no_fmem", {31'd0, forward_mem_enable}, 32'd0);

        // stray mem_done while idle is ignored
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        chk("stray_no_wb", {31'd0, wb_enable}, 32'd0);
        chk("stray_no_req", {31'd0, mem_req}, 32'd0);

        // rdy_in low freezes registers; forward_ex still follows inputs
        rdy_in = 1'b0;
        ex_alu(5'd12, 32'hC0DE);
        #1;
        chk("frz_fex", {31'd0, forward_ex_enable}, 32'd1);
        tick();
        chk("frz_no_wb", {31'd0, wb_enable}, 32'd0);
        rdy_in = 1'b1;
        expect_wb(5'd12, 32'hC0DE);
        tick();
        ex_none();
        chk("unfrz_wb", {31'd0, wb_enable}, 32'd1);
        tick();

        // async reset in MEM_WAIT abandons the access
        ex_load(5'd3, 32'h200);
        tick();
        ex_none();
        chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst_in = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_stall", {31'd0, stall_out}, 32'd0);
        chk("arst_fmem", {31'd0, forward_mem_enable}, 32'd0);
        #4;
        rst_in = 1'b1;
        tick();
        chk("post_rst_req", {31'd0, mem_req}, 32'd0);
        alu_5_1234();

        tick();
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
